uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser_if.sv | 32 +++
 rtl/uart_frame_parser.sv | 179 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte-in / payload-out handshake bundle for uart_frame_parser
//
// Signals:
//   rx_data, rx_done     : received byte and its one-cycle strobe (toward parser)
//   out_data, out_valid,
//   out_ready, out_last  : payload stream toward the consumer
//   frame_ok, frame_err  : one-cycle frame verdict pulses
//   busy                 : parser is not idle
// Modports: master = parser side, slave = UART receiver / consumer side.
interface uart_frame_parser_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_done;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  frame_ok;
    logic                  frame_err;
    logic                  busy;

    modport master (
        input  rx_data, rx_done, out_ready,
        output out_data, out_valid, out_last, frame_ok, frame_err, busy
    );

    modport slave (
        output rx_data, rx_done, out_ready,
        input  out_data, out_valid, out_last, frame_ok, frame_err, busy
    );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SYNC/LEN/payload[/CHK] frame parser with buffered payload drain
//
// Ports:
//   CLK100MHZ : system clock, rising edge
//   reset     : asynchronous active-low reset
//   bus       : uart_frame_parser_if.master (rx byte strobe in, payload stream out,
//               frame_ok / frame_err pulses, busy)
// Configuration macro: UART_FRAME_CHECKSUM_EN
//   defined   : frame is A5, N, N payload bytes, CHK (mod-2^DATA_WIDTH sum of N and payload)
//   undefined : frame is A5, N, N payload bytes; no CHK byte, no sum logic
module uart_frame_parser #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    uart_frame_parser_if.master bus
);
    // Index carries one extra bit so a count of MAX_LEN is representable.
    localparam int IW = $clog2(MAX_LEN) + 1;
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_PAY   = 3'd2;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd3;
`endif
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [DATA_WIDTH-1:0] SYNC_BYTE = DATA_WIDTH'(8'hA5);
    localparam logic [IW-1:0]         IDX_ONE   = IW'(1);
    localparam logic [GW-1:0]         GAP_LAST  = GW'(TIMEOUT_CYCLES - 1);

    logic [2:0]            r_state;
    logic [IW-1:0]         r_len;
    logic [IW-1:0]         r_wr_idx;
    logic [IW-1:0]         r_rd_idx;
    logic [GW-1:0]         r_gap;
    logic                  r_frame_ok;
    logic                  r_frame_err;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
`endif
    logic [DATA_WIDTH-1:0] r_buf [MAX_LEN];

    logic w_active;
    logic w_gap_exp;
    logic w_len_bad;
    logic w_wr_last;
    logic w_rd_last;
    logic w_drain;
    logic w_buf_we;

    // Gap timer only runs while a frame is being received.
    assign w_active  = (r_state == S_LEN) || (r_state == S_PAY)
`ifdef UART_FRAME_CHECKSUM_EN
                     || (r_state == S_CHK)
`endif
                     ;
    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_gap_exp = w_active && !bus.rx_done && (r_gap == GAP_LAST);
    assign w_len_bad = (bus.rx_data == '0) || (bus.rx_data > DATA_WIDTH'(MAX_LEN));
    assign w_wr_last = (r_wr_idx == r_len - IDX_ONE);
    assign w_rd_last = (r_rd_idx == r_len - IDX_ONE);
    assign w_drain   = (r_state == S_DRAIN);
    assign w_buf_we  = (r_state == S_PAY) && bus.rx_done;

    // Payload storage is intentionally left out of reset.
    always_ff @(posedge CLK100MHZ) begin
        if (w_buf_we) begin
            r_buf[r_wr_idx[AW-1:0]] <= bus.rx_data;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_gap       <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;

            if (!w_active || bus.rx_done || w_gap_exp) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + GW'(1);
            end

            if (w_gap_exp) begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.rx_done && (bus.rx_data == SYNC_BYTE)) begin
                            r_state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (bus.rx_done) begin
                            if (w_len_bad) begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_IDLE;
                            end else begin
                                r_len    <= IW'(bus.rx_data);
                                r_wr_idx <= '0;
                                r_rd_idx <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                                r_sum    <= bus.rx_data;
`endif
                                r_state  <= S_PAY;
                            end
                        end
                    end
                    S_PAY: begin
                        // A5 here is ordinary payload; no resync mid-frame.
                        if (bus.rx_done) begin
                            r_wr_idx <= r_wr_idx + IDX_ONE;
`ifdef UART_FRAME_CHECKSUM_EN
                            r_sum    <= r_sum + bus.rx_data;
                            if (w_wr_last) begin
                                r_state <= S_CHK;
                            end
`else
                            if (w_wr_last) begin
                                r_frame_ok <= 1'b1;
                                r_state    <= S_DRAIN;
                            end
`endif
                        end
                    end
`ifdef UART_FRAME_CHECKSUM_EN
                    S_CHK: begin
                        if (bus.rx_done) begin
                            if (bus.rx_data == r_sum) begin
                                r_frame_ok <= 1'b1;
                                r_state    <= S_DRAIN;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_IDLE;
                            end
                        end
                    end
`endif
                    S_DRAIN: begin
                        // Incoming bytes are dropped while the buffer drains.
                        if (bus.out_ready) begin
                            if (w_rd_last) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_rd_idx <= r_rd_idx + IDX_ONE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Stream outputs decode straight from state so reset clears them at once.
    assign bus.out_valid = w_drain;
    assign bus.out_data  = w_drain ? r_buf[r_rd_idx[AW-1:0]] : '0;
    assign bus.out_last  = w_drain && w_rd_last;
    assign bus.frame_ok  = r_frame_ok;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;
    localparam int T = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_parser_if #(.DATA_WIDTH(8)) bus ();

    uart_frame_parser #(
        .DATA_WIDTH    (8),
        .MAX_LEN       (16),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK100MHZ(clk),
        .reset    (rst_n),
        .bus      (bus.master)
    );

    int vectors     = 0;
    int miscompares = 0;
    int ok_cnt      = 0;
    int err_cnt     = 0;

    logic [8:0] exp_q [$];
    logic [7:0] pay [0:31];
    logic       stalled = 1'b0;
    logic [8:0] held    = '0;

    // Monitor: pulse counting, exclusivity, stall hold, scoreboard pop on transfer.
    always @(negedge clk) begin
        #1;
        if (bus.frame_ok === 1'b1) ok_cnt++;
        if (bus.frame_err === 1'b1) err_cnt++;
        if (bus.frame_ok === 1'b1 || bus.frame_err === 1'b1) begin
            vectors++;
            if (bus.frame_ok === 1'b1 && bus.frame_err === 1'b1) begin
                miscompares++;
                $display("FAIL pulse_exclusive: frame_ok=1 frame_err=1, required at most one");
            end
        end
        if (stalled && rst_n) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || {bus.out_last, bus.out_data} !== held) begin
                miscompares++;
                $display("FAIL stall_hold: valid=%b last/data=%h, required valid=1 last/data=%h",
                         bus.out_valid, {bus.out_last, bus.out_data}, held);
            end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_transfer: last/data=%h, required no transfer",
                         {bus.out_last, bus.out_data});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({bus.out_last, bus.out_data} !== e) begin
                    miscompares++;
                    $display("FAIL transfer: last/data=%h, required %h",
                             {bus.out_last, bus.out_data}, e);
                end
            end
        end
        stalled = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        held    = {bus.out_last, bus.out_data};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Caller sits on a negedge; the byte is sampled at the next posedge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit bad_chk, input bit expect_ok);
        logic [7:0] chk;
        chk = n[7:0];
        send_byte(8'hA5);
        send_byte(n[7:0]);
        for (int i = 0; i < n; i++) begin
            chk = chk + pay[i];
            if (expect_ok) exp_q.push_back({1'(i == n - 1), pay[i]});
            send_byte(pay[i]);
        end
        if (bad_chk) chk = ~chk;
`ifdef UART_FRAME_CHECKSUM_EN
        send_byte(chk);
`endif
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, bus.busy, n);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic check_delta(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic test_reset();
        bus.rx_data   = '0;
        bus.rx_done   = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.out_valid, bus.out_last, bus.frame_ok, bus.frame_err, bus.out_data} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {bus.busy, bus.out_valid, bus.out_last, bus.frame_ok, bus.frame_err, bus.out_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore();
        int ok0, err0;
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'h33);
        send_byte(8'h00);
        @(negedge clk);
        check_bit("idle_ignore_busy", bus.busy, 1'b0);
        check_delta("idle_ignore_pulses", (ok_cnt - ok0) + (err_cnt - err0), 0);
    endtask

    task automatic test_basic_frame();
        int ok0;
        ok0 = ok_cnt;
        bus.out_ready = 1'b1;
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(3, 1'b0, 1'b1);
        check_bit("basic_frame_ok", bus.frame_ok, 1'b1);
        vectors++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== {2'b10, 8'h11}) begin
            miscompares++;
            $display("FAIL basic_first: got %h, required %h", {bus.out_valid, bus.out_last, bus.out_data}, {2'b10, 8'h11});
        end
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== {2'b10, 8'h22}) begin
            miscompares++;
            $display("FAIL basic_second: got %h, required %h", {bus.out_valid, bus.out_last, bus.out_data}, {2'b10, 8'h22});
        end
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== {2'b11, 8'h33}) begin
            miscompares++;
            $display("FAIL basic_third: got %h, required %h", {bus.out_valid, bus.out_last, bus.out_data}, {2'b11, 8'h33});
        end
        @(negedge clk);
        check_bit("basic_done_busy", bus.busy, 1'b0);
        check_delta("basic_ok_count", ok_cnt - ok0, 1);
    endtask

    task automatic test_checksum();
        int ok0, err0;
        ok0 = ok_cnt; err0 = err_cnt;
        bus.out_ready = 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
        pay[0] = 8'h10; pay[1] = 8'h20;
        send_frame(2, 1'b1, 1'b0);
        check_bit("chk_bad_err", bus.frame_err, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_bit("chk_bad_no_valid", bus.out_valid, 1'b0);
            @(negedge clk);
        end
        check_delta("chk_bad_err_count", err_cnt - err0, 1);
        err0 = err_cnt;
`endif
        pay[0] = 8'h7F;
        send_frame(1, 1'b0, 1'b1);
        check_bit("chk_good_ok", bus.frame_ok, 1'b1);
        check_bit("chk_good_last", bus.out_last, 1'b1);
        wait_idle("chk_good");
        @(negedge clk);
        check_delta("chk_good_ok_count", ok_cnt - ok0, 1);
        check_delta("chk_good_err_count", err_cnt - err0, 0);
    endtask

    task automatic test_len_bounds();
        send_byte(8'hA5);
        send_byte(8'h00);
        check_bit("len_zero_err", bus.frame_err, 1'b1);
        @(negedge clk);
        check_bit("len_zero_idle", bus.busy, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h11);
        check_bit("len_17_err", bus.frame_err, 1'b1);
        @(negedge clk);
        check_bit("len_17_idle", bus.busy, 1'b0);
        // Full-size frame, with a SYNC value buried in the payload.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) pay[i] = 8'($urandom_range(0, 255));
        pay[5] = 8'hA5;
        send_frame(16, 1'b0, 1'b1);
        check_bit("len_16_ok", bus.frame_ok, 1'b1);
        wait_idle("len_16");
        @(negedge clk);
        check_delta("len_16_drained", exp_q.size(), 0);
    endtask

    task automatic test_timeout();
        int err0, ok0;
        bus.out_ready = 1'b1;
        err0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        repeat (T - 1) @(negedge clk);
        check_bit("timeout_pre_err", bus.frame_err, 1'b0);
        check_bit("timeout_pre_busy", bus.busy, 1'b1);
        @(negedge clk);
        check_bit("timeout_expiry_err", bus.frame_err, 1'b1);
        @(negedge clk);
        check_bit("timeout_after_busy", bus.busy, 1'b0);
        check_delta("timeout_err_count", err_cnt - err0, 1);

        // Byte lands exactly on the expiry cycle and must win.
        err0 = err_cnt; ok0 = ok_cnt;
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'h02});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        repeat (T - 1) @(negedge clk);
        send_byte(8'h02);
        check_bit("collision_no_err", bus.frame_err, 1'b0);
`ifdef UART_FRAME_CHECKSUM_EN
        check_bit("collision_busy", bus.busy, 1'b1);
        send_byte(8'h05);
`endif
        check_bit("collision_ok", bus.frame_ok, 1'b1);
        wait_idle("collision");
        @(negedge clk);
        check_delta("collision_err_count", err_cnt - err0, 0);
        check_delta("collision_ok_count", ok_cnt - ok0, 1);
    endtask

    task automatic test_drain_stall();
        logic [3:0] pat;
        int ok0, err0;
        pat = 4'b1001;
        bus.out_ready = 1'b0;
        pay[0] = 8'hC1; pay[1] = 8'hC2; pay[2] = 8'hA5; pay[3] = 8'hC4;
        send_frame(4, 1'b0, 1'b1);
        ok0 = ok_cnt; err0 = err_cnt;
        check_bit("drain_valid", bus.out_valid, 1'b1);
        for (int i = 0; i < 40 && bus.busy === 1'b1; i++) begin
            bus.out_ready = pat[i % 4];
            bus.rx_data   = 8'hA5;
            bus.rx_done   = (i == 2);
            @(negedge clk);
        end
        bus.rx_done   = 1'b0;
        bus.out_ready = 1'b1;
        check_bit("drain_done_busy", bus.busy, 1'b0);
        @(negedge clk);
        check_bit("drain_rx_ignored", bus.busy, 1'b0);
        check_delta("drain_remaining", exp_q.size(), 0);
        check_delta("drain_pulses", (ok_cnt - ok0) + (err_cnt - err0), 1);
    endtask

    task automatic test_reset_midframe();
        int ok0, err0;
        bus.out_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.out_valid, bus.out_last, bus.frame_ok, bus.frame_err, bus.out_data} !== 13'd0) begin
            miscompares++;
            $display("FAIL midframe_reset_outputs: got %h, required 0",
                     {bus.busy, bus.out_valid, bus.out_last, bus.frame_ok, bus.frame_err, bus.out_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ok0 = ok_cnt; err0 = err_cnt;
        repeat (3) @(negedge clk);
        check_delta("release_no_pulse", (ok_cnt - ok0) + (err_cnt - err0), 0);
        check_bit("release_idle", bus.busy, 1'b0);
        pay[0] = 8'hAA; pay[1] = 8'hBB;
        send_frame(2, 1'b0, 1'b1);
        check_bit("fresh_frame_ok", bus.frame_ok, 1'b1);
        wait_idle("fresh_frame");
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic_frame();
        test_checksum();
        test_len_bounds();
        test_timeout();
        test_drain_stall();
        test_reset_midframe();
        @(negedge clk);
        @(negedge clk);
        check_delta("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
